// File: rtl/fir_pkg.sv
// Shared types for the FIR tile configuration path: complex tap, tile command/tap-load words, sequencer states.
package fir_pkg;

    localparam int MAX_TAPS_DEFAULT = 32;
    localparam int DATA_W_DEFAULT   = 16;
    localparam int NUM_W_DEFAULT    = $clog2(MAX_TAPS_DEFAULT + 1);
    localparam int CNT_W_DEFAULT    = $clog2(MAX_TAPS_DEFAULT);

    typedef struct packed {
        logic [DATA_W_DEFAULT-1:0] data_r;
        logic [DATA_W_DEFAULT-1:0] data_i;
    } FIR_CPLX;

    typedef struct packed {
        logic                     valid;
        logic [NUM_W_DEFAULT-1:0] num;
        logic [1:0]               mode;
    } FIR_CONT_TO_TILE;

    typedef struct packed {
        logic                     valid;
        FIR_CPLX                  data;
        logic [CNT_W_DEFAULT-1:0] count;
    } FIR_TAP_LOAD;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_CONFIG,
        ST_GAP,
        ST_LOAD,
        ST_DONE
    } fir_state_t;

endpackage

// File: rtl/fir_tap_buf.sv
// Tap coefficient store: one synchronous write port, one combinational read port, async clear.
module fir_tap_buf
    import fir_pkg::*;
#(
    parameter int DEPTH = MAX_TAPS_DEFAULT,
    parameter int W     = 2 * DATA_W_DEFAULT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fir_tap_sequencer.sv
// Buffers host taps, then drives the FIR tile: command pulse, fixed gap, descending tap loads, done.
// FIR_TAP_SYM_EN: collect only ceil(num/2) taps and mirror them during the load phase.
module fir_tap_sequencer
    import fir_pkg::*;
#(
    parameter int MAX_TAPS   = MAX_TAPS_DEFAULT,
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter int GAP_CYCLES = 3,
    parameter int NUM_W      = $clog2(MAX_TAPS + 1),
    parameter int CNT_W      = $clog2(MAX_TAPS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [NUM_W-1:0]    cfg_num,
    input  logic [1:0]          cfg_mode,
    input  logic                tap_in_valid,
    output logic                tap_in_ready,
    input  logic [2*DATA_W-1:0] tap_in_data,
    output FIR_CONT_TO_TILE     from_cont,
    output FIR_TAP_LOAD         input_tap,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    fir_state_t      r_state, w_state;
    logic [NUM_W-1:0] r_num;
    logic [1:0]      r_mode;
    logic [CNT_W-1:0] r_idx, r_last, r_cnt, w_cnt;
    logic [GW-1:0]   r_gap, w_gap;
    logic            r_cfg_ready, r_tap_in_ready, r_busy, r_done, r_err;
    logic            w_done, w_err, w_cfg_acc, w_tap_acc, w_num_ok;
    FIR_CONT_TO_TILE r_from_cont, w_from_cont;
    FIR_TAP_LOAD     r_input_tap, w_input_tap;
    logic [CNT_W-1:0] w_load_cnt, w_raddr;
    logic [2*DATA_W-1:0] w_rdata;
    logic [NUM_W-1:0] w_need;

    // Count of the tap presented in the next cycle; the buffer is read one cycle ahead so the load word is registered.
    assign w_load_cnt = (r_state == ST_GAP) ? CNT_W'(r_num - 1'b1) : (r_cnt - 1'b1);

`ifdef FIR_TAP_SYM_EN
    logic [CNT_W-1:0] w_mirror;
    assign w_mirror = CNT_W'(r_num - 1'b1 - NUM_W'(w_load_cnt));
    assign w_raddr  = (w_load_cnt < w_mirror) ? w_load_cnt : w_mirror;
    assign w_need   = NUM_W'((cfg_num + 1'b1) >> 1);
`else
    assign w_raddr  = w_load_cnt;
    assign w_need   = cfg_num;
`endif

    assign w_num_ok = (cfg_num != '0) && (int'(cfg_num) <= MAX_TAPS);

    fir_tap_buf #(
        .DEPTH (MAX_TAPS),
        .W     (2 * DATA_W),
        .AW    (CNT_W)
    ) u_buf (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_we    (w_tap_acc),
        .i_waddr (r_idx),
        .i_wdata (tap_in_data),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_gap       = r_gap;
        w_from_cont = '0;
        w_input_tap = '0;
        w_done      = 1'b0;
        w_err       = 1'b0;
        w_cfg_acc   = 1'b0;
        w_tap_acc   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cfg_valid && r_cfg_ready) begin
                    if (w_num_ok) begin
                        w_cfg_acc = 1'b1;
                        w_state   = ST_COLLECT;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            ST_COLLECT: begin
                if (tap_in_valid && r_tap_in_ready) begin
                    w_tap_acc = 1'b1;
                    if (r_idx == r_last) begin
                        w_state           = ST_CONFIG;
                        w_from_cont.valid = 1'b1;
                        w_from_cont.num   = r_num;
                        w_from_cont.mode  = r_mode;
                    end
                end
            end
            ST_CONFIG: begin
                w_state = ST_GAP;
                w_gap   = '0;
            end
            ST_GAP: begin
                if (r_gap == GW'(GAP_CYCLES - 1)) begin
                    w_state           = ST_LOAD;
                    w_cnt             = w_load_cnt;
                    w_input_tap.valid = 1'b1;
                    w_input_tap.data  = w_rdata;
                    w_input_tap.count = w_load_cnt;
                end else begin
                    w_gap = r_gap + 1'b1;
                end
            end
            ST_LOAD: begin
                if (r_cnt == '0) begin
                    w_state = ST_DONE;
                    w_done  = 1'b1;
                end else begin
                    w_cnt             = w_load_cnt;
                    w_input_tap.valid = 1'b1;
                    w_input_tap.data  = w_rdata;
                    w_input_tap.count = w_load_cnt;
                end
            end
            ST_DONE:  w_state = ST_IDLE;
            default:  w_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_num          <= '0;
            r_mode         <= '0;
            r_idx          <= '0;
            r_last         <= '0;
            r_cnt          <= '0;
            r_gap          <= '0;
            r_from_cont    <= '0;
            r_input_tap    <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_err          <= 1'b0;
            r_cfg_ready    <= 1'b1;
            r_tap_in_ready <= 1'b0;
        end else begin
            r_state        <= w_state;
            r_cnt          <= w_cnt;
            r_gap          <= w_gap;
            r_from_cont    <= w_from_cont;
            r_input_tap    <= w_input_tap;
            r_done         <= w_done;
            r_err          <= w_err;
            r_busy         <= (w_state != ST_IDLE);
            r_cfg_ready    <= (w_state == ST_IDLE);
            r_tap_in_ready <= (w_state == ST_COLLECT);
            if (w_cfg_acc) begin
                r_num  <= cfg_num;
                r_mode <= cfg_mode;
                r_idx  <= '0;
                r_last <= CNT_W'(w_need - 1'b1);
            end else if (w_tap_acc) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign cfg_ready    = r_cfg_ready;
    assign tap_in_ready = r_tap_in_ready;
    assign from_cont    = r_from_cont;
    assign input_tap    = r_input_tap;
    assign busy         = r_busy;
    assign done         = r_done;
    assign err          = r_err;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Randomized bench for fir_tap_sequencer against a cycle-schedule model derived from the timing rules.
module tb_fir_tap_sequencer;
    import fir_pkg::*;

    localparam int G  = 3;
    localparam int MT = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cfg_valid = 1'b0;
    logic            cfg_ready;
    logic [5:0]      cfg_num = '0;
    logic [1:0]      cfg_mode = '0;
    logic            tap_in_valid = 1'b0;
    logic            tap_in_ready;
    logic [31:0]     tap_in_data = '0;
    FIR_CONT_TO_TILE from_cont;
    FIR_TAP_LOAD     input_tap;
    logic            busy, done, err;

    fir_tap_sequencer #(
        .MAX_TAPS   (MT),
        .DATA_W     (16),
        .GAP_CYCLES (G)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_num      (cfg_num),
        .cfg_mode     (cfg_mode),
        .tap_in_valid (tap_in_valid),
        .tap_in_ready (tap_in_ready),
        .tap_in_data  (tap_in_data),
        .from_cont    (from_cont),
        .input_tap    (input_tap),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    int nchecks = 0;
    int nerr    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            if (nerr <= 40)
                $display("FAIL %s: got %h expected %h (time %0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        nchecks++;
        nerr++;
        $display("FAIL %s: bound expired (time %0t)", name, $time);
    endtask

    // Model: 0 idle, 1 collecting, 2 sequencing from the edge that took the last tap.
    int          cyc = 0;
    int          m_mode = 0;
    int          m_num = 0;
    int          m_cmode = 0;
    int          m_need = 0;
    int          m_T = 0;
    int          m_err_at = -1;
    logic [31:0] m_taps[$];

    function automatic int need_of(input int n);
`ifdef FIR_TAP_SYM_EN
        return (n + 1) / 2;
`else
        return n;
`endif
    endfunction

    function automatic int src_idx(input int c, input int n);
`ifdef FIR_TAP_SYM_EN
        return (c < n - 1 - c) ? c : n - 1 - c;
`else
        return c + 0 * n;
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0;
            m_taps.delete();
            m_err_at = -1;
        end else begin
            cyc = cyc + 1;
            case (m_mode)
                0: if (cfg_valid) begin
                    if (cfg_num >= 1 && cfg_num <= MT) begin
                        m_mode  = 1;
                        m_num   = int'(cfg_num);
                        m_cmode = int'(cfg_mode);
                        m_need  = need_of(m_num);
                        m_taps.delete();
                    end else begin
                        m_err_at = cyc;
                    end
                end
                1: if (tap_in_valid) begin
                    m_taps.push_back(tap_in_data);
                    if (m_taps.size() == m_need) begin
                        m_mode = 2;
                        m_T    = cyc;
                    end
                end
                default: if (cyc == m_T + 2 + G + m_num) m_mode = 0;
            endcase
        end
    end

    FIR_TAP_LOAD     obs_loads[$];
    FIR_CONT_TO_TILE obs_fc;
    int              obs_fc_cnt = 0;
    int              obs_err = 0;
    int              fc_cyc = 0;
    int              done_cyc = 0;

    always @(negedge clk) begin
        logic [8:0]  exp_fc;
        logic [37:0] exp_tap;
        logic [4:0]  exp_ctl;
        int          c;
        if (!rst) begin
            exp_fc  = '0;
            exp_tap = '0;
            exp_ctl = {m_mode == 0, m_mode == 1, m_mode != 0,
                       (m_mode == 2) && (cyc == m_T + G + m_num + 1),
                       m_err_at == cyc};
            if (m_mode == 2 && cyc == m_T)
                exp_fc = {1'b1, 6'(m_num), 2'(m_cmode)};
            if (m_mode == 2 && cyc >= m_T + G + 1 && cyc <= m_T + G + m_num) begin
                c = m_num - 1 - (cyc - (m_T + G + 1));
                exp_tap = {1'b1, m_taps[src_idx(c, m_num)], 5'(c)};
            end
            chk("ctl{cfg_ready,tap_in_ready,busy,done,err}", 64'({cfg_ready, tap_in_ready, busy, done, err}), 64'(exp_ctl));
            chk("from_cont", 64'(from_cont), 64'(exp_fc));
            chk("input_tap", 64'(input_tap), 64'(exp_tap));
            if (input_tap.valid) obs_loads.push_back(input_tap);
            if (from_cont.valid) begin
                obs_fc = from_cont;
                obs_fc_cnt++;
                fc_cyc = cyc;
            end
            if (done) done_cyc = cyc;
            if (err) obs_err++;
        end
    end

    logic [31:0] src[MT];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int b = 0;
        while (m_mode != 0 && b < 300) begin
            tick();
            b++;
        end
        if (b >= 300) fail_now("wait_idle");
    endtask

    // abort>0 asserts reset in the load cycle following that many tap loads.
    task automatic run_seq(input int num, input int mode, input bit toggle, input bit hold, input int abort);
        int b;
        wait_idle();
        cfg_valid = 1'b1;
        cfg_num   = 6'(num);
        cfg_mode  = 2'(mode);
        tick();
        if (!hold) cfg_valid = 1'b0;
        if (num < 1 || num > MT) begin
            cfg_valid = 1'b0;
            tick();
            return;
        end
        b = 0;
        while (m_mode == 1 && b < 400) begin
            tap_in_valid = toggle ? ((b % 2) == 0) : 1'b1;
            tap_in_data  = src[m_taps.size()];
            tick();
            b++;
        end
        tap_in_valid = 1'b0;
        if (b >= 400) fail_now("collect");
        b = 0;
        while (m_mode != 0 && b < 400) begin
            if (hold && cyc == m_T + G + m_num + 1) cfg_valid = 1'b0;
            if (abort > 0 && cyc == m_T + G + 1 + abort) begin
                rst = 1'b1;
                #1;
                chk("reset_abort_outputs",
                    64'({from_cont, input_tap, busy, done, err, cfg_ready, tap_in_ready}),
                    64'({9'b0, 38'b0, 3'b000, 2'b10}));
                tick();
                rst = 1'b0;
                cfg_valid = 1'b0;
                return;
            end
            tick();
            b++;
        end
        cfg_valid = 1'b0;
        if (b >= 400) fail_now("sequence");
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state",
            64'({from_cont, input_tap, busy, done, err, cfg_ready, tap_in_ready}),
            64'({9'b0, 38'b0, 3'b000, 2'b10}));
        rst = 1'b0;
        tick();

        // Test 1: num=6 mode=1, h[k]=k+1 on data_r
        for (int i = 0; i < MT; i++) src[i] = {16'(i + 1), 16'h0};
        obs_loads.delete();
        run_seq(6, 1, 1'b0, 1'b0, 0);
        chk("t1_from_cont", 64'(obs_fc), 64'({1'b1, 6'd6, 2'd1}));
        chk("t1_nloads", 64'(obs_loads.size()), 64'd6);
`ifndef FIR_TAP_SYM_EN
        for (int i = 0; i < 6 && i < obs_loads.size(); i++)
            chk("t1_load", 64'(obs_loads[i]), 64'({1'b1, 16'(6 - i), 16'h0, 5'(5 - i)}));
`endif
        chk("t1_done_gap", 64'(done_cyc - fc_cyc), 64'(1 + G + 6));

        // Test 2: out-of-range commands
        obs_err = 0;
        run_seq(0, 2, 1'b0, 1'b0, 0);
        run_seq(33, 3, 1'b0, 1'b0, 0);
        chk("t2_err_pulses", 64'(obs_err), 64'd2);

        // Test 3: toggling tap_in_valid, cfg_valid held throughout
        for (int i = 0; i < MT; i++) src[i] = $urandom;
        obs_fc_cnt = 0;
        run_seq(4, 2, 1'b1, 1'b1, 0);
        repeat (3) tick();
        chk("t3_single_command", 64'(obs_fc_cnt), 64'd1);

        // Test 4: full buffer
        for (int i = 0; i < MT; i++) src[i] = $urandom;
        obs_loads.delete();
        run_seq(32, 0, 1'b0, 1'b0, 0);
        chk("t4_nloads", 64'(obs_loads.size()), 64'd32);
        chk("t4_done_gap", 64'(done_cyc - fc_cyc), 64'(1 + G + 32));
        if (obs_loads.size() > 0) chk("t4_first_count", 64'(obs_loads[0].count), 64'd31);

        // Test 5: reset during load, then a clean num=2 run with fresh taps
        for (int i = 0; i < MT; i++) src[i] = $urandom;
        obs_loads.delete();
        run_seq(6, 1, 1'b0, 1'b0, 2);
        chk("t5_loads_before_reset", 64'(obs_loads.size()), 64'd2);
        tick();
        src[0] = 32'h1111_2222;
        src[1] = 32'h3333_4444;
        obs_loads.delete();
        run_seq(2, 3, 1'b0, 1'b0, 0);
        chk("t5_nloads", 64'(obs_loads.size()), 64'd2);
`ifdef FIR_TAP_SYM_EN
        if (obs_loads.size() == 2) begin
            chk("t5_load1", 64'(obs_loads[0]), 64'({1'b1, 32'h1111_2222, 5'd1}));
            chk("t5_load0", 64'(obs_loads[1]), 64'({1'b1, 32'h1111_2222, 5'd0}));
        end
`else
        if (obs_loads.size() == 2) begin
            chk("t5_load1", 64'(obs_loads[0]), 64'({1'b1, 32'h3333_4444, 5'd1}));
            chk("t5_load0", 64'(obs_loads[1]), 64'({1'b1, 32'h1111_2222, 5'd0}));
        end
`endif

`ifdef FIR_TAP_SYM_EN
        // Test 6: symmetric taps, num=5 from 1,2,3
        for (int i = 0; i < MT; i++) src[i] = {16'(i + 1), 16'h0};
        obs_loads.delete();
        run_seq(5, 0, 1'b0, 1'b0, 0);
        chk("t6_nloads", 64'(obs_loads.size()), 64'd5);
        for (int i = 0; i < 5 && i < obs_loads.size(); i++)
            chk("t6_load", 64'(obs_loads[i]),
                64'({1'b1, 16'((i < 3) ? i + 1 : 5 - i), 16'h0, 5'(4 - i)}));
`endif

        // Randomized sequences
        for (int r = 0; r < 20; r++) begin
            int n;
            for (int i = 0; i < MT; i++) src[i] = $urandom;
            n = (($urandom % 8) == 0) ? (($urandom % 2) ? 0 : int'($urandom_range(33, 63)))
                                      : int'($urandom_range(1, MT));
            run_seq(n, int'($urandom % 4), 1'($urandom % 2), 1'($urandom % 2), 0);
            repeat ($urandom_range(0, 3)) tick();
        end

        wait_idle();
        repeat (4) tick();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
